// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: state encoding and frame-length constants for fifo_uart_tx
package fifo_uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_POP    = 3'd1;
    localparam state_t S_LOAD   = 3'd2;
    localparam state_t S_START  = 3'd3;
    localparam state_t S_DATA   = 3'd4;
    localparam state_t S_STOP   = 3'd5;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam state_t S_PARITY = 3'd6;
    localparam int PARITY_BITS  = 1;
`else
    localparam int PARITY_BITS  = 0;
`endif

    // POP and LOAD precede the first serial bit
    localparam int SETUP_CYCLES = 2;
    // start + stop bits
    localparam int FRAMING_BITS = 2;

    // cycles from the pop pulse to the last stop cycle inclusive
    function automatic int frame_cycles(input int dw, input int cpb);
        return SETUP_CYCLES + (dw + FRAMING_BITS + PARITY_BITS) * cpb;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO-side handshake plus serial/status outputs of the transmitter
interface fifo_uart_tx_if #(parameter int DATA_WIDTH = 4);

    logic                  tx_en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output tx_en, fifo_empty, fifo_data,
        input  fifo_rd_en, tx, busy, frame_done
    );

    modport slave (
        input  tx_en, fifo_empty, fifo_data,
        output fifo_rd_en, tx, busy, frame_done
    );

endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: counts CLKS_PER_BIT cycles per bit, flags the last cycle of each bit period
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic bit_last_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_last_o = (cnt_q == LAST);

    // wrap at each bit boundary, hold at zero while cleared
    always_comb begin
        cnt_d = (clr_i || bit_last_o) ? '0 : cnt_q + 1'b1;
    end

    // counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO and sends them as LSB-first start/data/stop frames;
// defining FIFO_UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.slave  bus
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  bit_last;
    logic                  baud_clr;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  par_q;
`endif

    // baud counter only runs while a serial bit is on the line
    assign baud_clr = (state_q == S_IDLE) || (state_q == S_POP) || (state_q == S_LOAD);

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (baud_clr),
        .bit_last_o(bit_last)
    );

    // state, counters, shift register and serial line registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    // even parity of the word as captured from the FIFO
    always_ff @(posedge clk) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= (state_q == S_LOAD) ? ^bus.fifo_data : par_q;
    end
`endif

    // next-state logic; tx_en and fifo_empty matter only in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = (bus.tx_en && !bus.fifo_empty) ? S_POP : S_IDLE;
            S_POP:    state_d = S_LOAD;
            S_LOAD:   state_d = S_START;
            S_START:  state_d = bit_last ? S_DATA : S_START;
`ifdef FIFO_UART_TX_PARITY_EN
            S_DATA:   state_d = (bit_last && bit_q == LAST_BIT) ? S_PARITY : S_DATA;
            S_PARITY: state_d = bit_last ? S_STOP : S_PARITY;
`else
            S_DATA:   state_d = (bit_last && bit_q == LAST_BIT) ? S_STOP : S_DATA;
`endif
            S_STOP:   state_d = bit_last ? S_IDLE : S_STOP;
            default:  state_d = S_IDLE;
        endcase
    end

    // datapath next values; tx is computed from the next state so the line changes with it
    always_comb begin
        bit_d   = (state_q == S_DATA && bit_last) ? ((bit_q == LAST_BIT) ? '0 : bit_q + 1'b1) : bit_q;
        shift_d = (state_q == S_LOAD) ? bus.fifo_data :
                  (state_q == S_DATA && bit_last) ? shift_q >> 1 : shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        tx_d    = (state_d == S_START)  ? 1'b0 :
                  (state_d == S_DATA)   ? shift_d[0] :
                  (state_d == S_PARITY) ? par_q : 1'b1;
`else
        tx_d    = (state_d == S_START) ? 1'b0 :
                  (state_d == S_DATA)  ? shift_d[0] : 1'b1;
`endif
    end

    assign bus.fifo_rd_en = (state_q == S_POP);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.frame_done = (state_q == S_STOP) && bit_last;
    assign bus.tx         = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of fifo_uart_tx against a small behavioural FIFO
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam bit PAR   = 1'b1;
    localparam int FRAME = 30;
`else
    localparam bit PAR   = 1'b0;
    localparam int FRAME = 26;
`endif
    localparam int P = FRAME + 1;

    logic clk = 1'b0;
    logic reset;
    int compared = 0;
    int mismatched = 0;

    fifo_uart_tx_if #(.DATA_WIDTH(4)) bus ();

    fifo_uart_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] fq[$];
    logic       fe = 1'b1;
    logic [3:0] fd = 4'h0;
    assign bus.fifo_empty = fe;
    assign bus.fifo_data  = fd;

    // registered FIFO model: data_out valid the cycle after rd_en, empty updates one cycle late
    always @(posedge clk) begin
        fe <= (fq.size() == 0);
        if (bus.fifo_rd_en && fq.size() != 0) fd <= fq.pop_front();
    end

    int   rd_cnt = 0;
    int   done_cnt = 0;
    int   consec = 0;
    logic prev_rd = 1'b0;

    always @(negedge clk) begin
        if (bus.fifo_rd_en) rd_cnt++;
        if (bus.fifo_rd_en && prev_rd) consec++;
        prev_rd = bus.fifo_rd_en;
        if (bus.frame_done) done_cnt++;
    end

    logic cap_tx[1:200];
    logic cap_fd[1:200];
    logic cap_busy[1:200];
    logic cap_rd[1:200];

    function automatic logic exp_tx(input logic [3:0] w, input int k);
        int b;
        if (k <= 2) return 1'b1;
        b = (k - 3) / 4;
        if (b == 0) return 1'b0;
        if (b <= 4) return w[b-1];
        if (PAR && b == 5) return ^w;
        return 1'b1;
    endfunction

    task automatic wait_pop(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.fifo_rd_en) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic capture(input int n, input int drop_k, input int rst_k);
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clk);
            cap_tx[k]   = bus.tx;
            cap_fd[k]   = bus.frame_done;
            cap_busy[k] = bus.busy;
            cap_rd[k]   = bus.fifo_rd_en;
            if (k == drop_k) bus.tx_en = 1'b0;
            if (k == rst_k) reset = 1'b1;
            if (rst_k != 0 && k == rst_k + 1) reset = 1'b0;
        end
    endtask

    task automatic test_reset;
        int r0, bad;
        reset = 1'b1;
        bus.tx_en = 1'b1;
        repeat (3) @(negedge clk);
        compared++; if (bus.tx !== 1'b1) begin mismatched++; $display("FAIL reset_tx got=%b exp=1", bus.tx); end
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        compared++; if (bus.fifo_rd_en !== 1'b0) begin mismatched++; $display("FAIL reset_rd_en got=%b exp=0", bus.fifo_rd_en); end
        compared++; if (bus.frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); end
        reset = 1'b0;
        r0 = rd_cnt;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) bad++;
        end
        compared++; if (bad != 0) begin mismatched++; $display("FAIL empty_idle bad_cycles got=%0d exp=0", bad); end
        compared++; if (rd_cnt != r0) begin mismatched++; $display("FAIL empty_no_pop pops got=%0d exp=0", rd_cnt - r0); end
    endtask

    task automatic test_single;
        bit ok;
        int d0;
        d0 = done_cnt;
        fq.push_back(4'hA);
        wait_pop(20, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL single_pop got=none exp=pulse"); end
        if (ok) begin
            capture(FRAME + 2, 0, 0);
            for (int k = 1; k <= FRAME + 2; k++) begin
                compared++; if (cap_tx[k] !== ((k <= FRAME) ? exp_tx(4'hA, k) : 1'b1)) begin mismatched++; $display("FAIL single_tx k=%0d got=%b exp=%b", k, cap_tx[k], (k <= FRAME) ? exp_tx(4'hA, k) : 1'b1); end
                compared++; if (cap_fd[k] !== (k == FRAME)) begin mismatched++; $display("FAIL single_frame_done k=%0d got=%b exp=%b", k, cap_fd[k], k == FRAME); end
                compared++; if (cap_rd[k] !== (k == 1)) begin mismatched++; $display("FAIL single_rd_en k=%0d got=%b exp=%b", k, cap_rd[k], k == 1); end
                compared++; if (cap_busy[k] !== (k <= FRAME)) begin mismatched++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, cap_busy[k], k <= FRAME); end
            end
            compared++; if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - d0); end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int r0, j, l;
        logic [3:0] ws[3];
        logic et, ef, er, eb;
        ws = '{4'h3, 4'h5, 4'hC};
        r0 = rd_cnt;
        foreach (ws[i]) fq.push_back(ws[i]);
        wait_pop(20, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL b2b_pop got=none exp=pulse"); end
        if (ok) begin
            capture(3 * P + 1, 0, 0);
            for (int k = 1; k <= 3 * P + 1; k++) begin
                j = (k - 1) / P;
                l = (k - 1) % P + 1;
                if (j < 3 && l <= FRAME) begin
                    et = exp_tx(ws[j], l); ef = (l == FRAME); er = (l == 1); eb = 1'b1;
                end else begin
                    et = 1'b1; ef = 1'b0; er = 1'b0; eb = 1'b0;
                end
                compared++; if (cap_tx[k] !== et) begin mismatched++; $display("FAIL b2b_tx k=%0d got=%b exp=%b", k, cap_tx[k], et); end
                compared++; if (cap_fd[k] !== ef) begin mismatched++; $display("FAIL b2b_frame_done k=%0d got=%b exp=%b", k, cap_fd[k], ef); end
                compared++; if (cap_rd[k] !== er) begin mismatched++; $display("FAIL b2b_rd_en k=%0d got=%b exp=%b", k, cap_rd[k], er); end
                compared++; if (cap_busy[k] !== eb) begin mismatched++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, cap_busy[k], eb); end
            end
        end
        repeat (10) @(negedge clk);
        compared++; if (bus.fifo_empty !== 1'b1) begin mismatched++; $display("FAIL b2b_empty got=%b exp=1", bus.fifo_empty); end
        compared++; if (rd_cnt - r0 != 3) begin mismatched++; $display("FAIL b2b_pop_count got=%0d exp=3", rd_cnt - r0); end
    endtask

    task automatic test_tx_en_drop;
        bit ok;
        int r0, bad;
        r0 = rd_cnt;
        fq.push_back(4'h6);
        fq.push_back(4'h9);
        wait_pop(20, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL drop_pop1 got=none exp=pulse"); end
        if (ok) begin
            capture(FRAME, 10, 0);
            for (int k = 1; k <= FRAME; k++) begin
                compared++; if (cap_tx[k] !== exp_tx(4'h6, k)) begin mismatched++; $display("FAIL drop_tx1 k=%0d got=%b exp=%b", k, cap_tx[k], exp_tx(4'h6, k)); end
                compared++; if (cap_fd[k] !== (k == FRAME)) begin mismatched++; $display("FAIL drop_frame_done k=%0d got=%b exp=%b", k, cap_fd[k], k == FRAME); end
            end
        end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0 || bus.tx !== 1'b1) bad++;
        end
        compared++; if (bad != 0) begin mismatched++; $display("FAIL drop_hold bad_cycles got=%0d exp=0", bad); end
        compared++; if (rd_cnt - r0 != 1) begin mismatched++; $display("FAIL drop_pop_count got=%0d exp=1", rd_cnt - r0); end
        bus.tx_en = 1'b1;
        wait_pop(10, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL drop_pop2 got=none exp=pulse"); end
        if (ok) begin
            capture(FRAME + 1, 0, 0);
            for (int k = 1; k <= FRAME; k++) begin
                compared++; if (cap_tx[k] !== exp_tx(4'h9, k)) begin mismatched++; $display("FAIL drop_tx2 k=%0d got=%b exp=%b", k, cap_tx[k], exp_tx(4'h9, k)); end
            end
            compared++; if (cap_fd[FRAME] !== 1'b1) begin mismatched++; $display("FAIL drop_done2 got=%b exp=1", cap_fd[FRAME]); end
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int d0, bad;
        d0 = done_cnt;
        fq.push_back(4'h5);
        fq.push_back(4'hE);
        wait_pop(20, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL rstmid_pop got=none exp=pulse"); end
        if (ok) begin
            capture(13, 0, 11);
            compared++; if (cap_tx[11] !== 1'b0) begin mismatched++; $display("FAIL rstmid_bit1 got=%b exp=0", cap_tx[11]); end
            compared++; if (cap_tx[12] !== 1'b1) begin mismatched++; $display("FAIL rstmid_tx got=%b exp=1", cap_tx[12]); end
            compared++; if (cap_busy[12] !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy got=%b exp=0", cap_busy[12]); end
            compared++; if (cap_rd[13] !== 1'b1) begin mismatched++; $display("FAIL rstmid_repop got=%b exp=1", cap_rd[13]); end
            bad = 0;
            for (int k = 1; k <= 13; k++) if (cap_fd[k] !== 1'b0) bad++;
            compared++; if (bad != 0) begin mismatched++; $display("FAIL rstmid_no_done got=%0d exp=0", bad); end
            wait_pop(5, ok);
            compared++; if (!ok) begin mismatched++; $display("FAIL rstmid_pop2 got=none exp=pulse"); end
            if (ok) begin
                capture(FRAME + 1, 0, 0);
                for (int k = 1; k <= FRAME; k++) begin
                    compared++; if (cap_tx[k] !== exp_tx(4'hE, k)) begin mismatched++; $display("FAIL rstmid_tx2 k=%0d got=%b exp=%b", k, cap_tx[k], exp_tx(4'hE, k)); end
                end
                compared++; if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL rstmid_done_count got=%0d exp=1", done_cnt - d0); end
            end
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity;
        bit ok;
        logic bits[7];
        bits = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        fq.push_back(4'h7);
        wait_pop(20, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL parity_pop got=none exp=pulse"); end
        if (ok) begin
            capture(FRAME + 1, 0, 0);
            for (int b = 0; b < 7; b++) begin
                compared++; if (cap_tx[4 + 4 * b] !== bits[b]) begin mismatched++; $display("FAIL parity_bit b=%0d got=%b exp=%b", b, cap_tx[4 + 4 * b], bits[b]); end
            end
            compared++; if (cap_fd[30] !== 1'b1) begin mismatched++; $display("FAIL parity_done got=%b exp=1", cap_fd[30]); end
            compared++; if (cap_busy[31] !== 1'b0) begin mismatched++; $display("FAIL parity_len got=%b exp=0", cap_busy[31]); end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.tx_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_tx_en_drop();
        test_reset_mid_frame();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        repeat (5) @(negedge clk);
        compared++; if (consec != 0) begin mismatched++; $display("FAIL rd_en_consecutive got=%0d exp=0", consec); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
